// File: rtl/fpc_tag_pool.sv
// fpc_tag_pool: per-channel read-tag allocator with in-order retirement for the FPC read path.
//
// Each of the 4 channels owns a ring of TAGS slots. A free slot (the ring head) is presented to
// the read-request multiplexer. The multiplexer consumes it with rr_ready, which allocates the
// slot. Completions mark slots done. Slots retire strictly in issue order from the ring tail,
// one per channel per cycle, with a registered ret_valid pulse for each retirement.
//
// Completion tag layout: c_tag = {2'b00, ch[1:0], 1'b0, tag_low[2:0]}. A nonzero reserved bit
// is a protocol error.
//
// Ports
//   clock                 in   single clock domain
//   reset                 in   asynchronous active-low reset, clears all state
//   enable[3:0]           in   per-channel allocation enable
//   rr_valid[3:0]         out  channel has a tag available (registers only, no rr_ready path)
//   rr_ready[3:0]         in   multiplexer consumed the presented tag this cycle
//   rr0..rr3_tag_low[2:0] out  presented tag per channel (ring head)
//   c_valid, c_tag[7:0]   in   final completion for a full tag
//   ret_valid[3:0]        out  one-cycle pulse per in-order retirement
//   busy[3:0]             out  channel holds at least one allocated tag
//   outstanding[5:0]      out  total allocated tags across all channels
//   err                   out  sticky protocol error, cleared only by reset
module fpc_tag_pool #(
    parameter int unsigned TAGS            = 8,
    parameter int unsigned MAX_OUTSTANDING = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] enable,
    output logic [3:0] rr_valid,
    input  logic [3:0] rr_ready,
    output logic [2:0] rr0_tag_low,
    output logic [2:0] rr1_tag_low,
    output logic [2:0] rr2_tag_low,
    output logic [2:0] rr3_tag_low,
    input  logic       c_valid,
    input  logic [7:0] c_tag,
    output logic [3:0] ret_valid,
    output logic [3:0] busy,
    output logic [5:0] outstanding,
    output logic       err
);

    localparam int unsigned NumCh   = 4;
    localparam logic [3:0]  CntFull = 4'(TAGS);
    localparam logic [5:0]  OutCap  = 6'(MAX_OUTSTANDING);

    logic [2:0] head_q  [NumCh];
    logic [2:0] head_d  [NumCh];
    logic [2:0] tail_q  [NumCh];
    logic [2:0] tail_d  [NumCh];
    logic [3:0] cnt_q   [NumCh];
    logic [3:0] cnt_d   [NumCh];
    logic [7:0] alloc_q [NumCh];
    logic [7:0] alloc_d [NumCh];
    logic [7:0] done_q  [NumCh];
    logic [7:0] done_d  [NumCh];
    logic [5:0] out_q, out_d;
    logic       err_q, err_d;
    logic [3:0] ret_q, ret_d;
    // Held low by reset so rr_valid stays low until the first clock edge after release.
    logic       active_q;

    logic [1:0] c_ch;
    logic [2:0] c_t;
    logic       c_ok;

    assign c_ch = c_tag[5:4];
    assign c_t  = c_tag[2:0];
    assign c_ok = (c_tag[7:6] == 2'b00) && !c_tag[3] && alloc_q[c_ch][c_t] && !done_q[c_ch][c_t];

    always_comb begin
        for (int i = 0; i < NumCh; i++) begin
            rr_valid[i] = active_q && enable[i] && (cnt_q[i] < CntFull) && (out_q < OutCap);
        end
    end

    always_comb begin
        logic [5:0] room;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        alloc_d = alloc_q;
        done_d  = done_q;
        out_d   = out_q;
        err_d   = err_q;
        ret_d   = '0;
        room    = out_q;
        for (int i = 0; i < NumCh; i++) begin
            // Retirement decision uses registered state only.
            if ((cnt_q[i] != 4'd0) && done_q[i][tail_q[i]]) begin
                ret_d[i]             = 1'b1;
                alloc_d[i][tail_q[i]] = 1'b0;
                done_d[i][tail_q[i]]  = 1'b0;
                tail_d[i]            = tail_q[i] + 3'd1;
                cnt_d[i]             = cnt_d[i] - 4'd1;
                out_d                = out_d - 6'd1;
            end
            // The multiplexer issues one request per cycle, so the cap normally holds through
            // rr_valid alone; the running headroom check keeps it exact if several channels
            // are consumed together, and such an over-commit is flagged as a protocol error.
            if (rr_ready[i]) begin
                if (rr_valid[i] && (room < OutCap)) begin
                    room                  = room + 6'd1;
                    alloc_d[i][head_q[i]] = 1'b1;
                    head_d[i]             = head_q[i] + 3'd1;
                    cnt_d[i]              = cnt_d[i] + 4'd1;
                    out_d                 = out_d + 6'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        // A valid completion never targets a slot retiring this cycle: that slot is already done.
        if (c_valid) begin
            if (c_ok) begin
                done_d[c_ch][c_t] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumCh; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                cnt_q[i]   <= '0;
                alloc_q[i] <= '0;
                done_q[i]  <= '0;
            end
            out_q    <= '0;
            err_q    <= 1'b0;
            ret_q    <= '0;
            active_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            alloc_q  <= alloc_d;
            done_q   <= done_d;
            out_q    <= out_d;
            err_q    <= err_d;
            ret_q    <= ret_d;
            active_q <= 1'b1;
        end
    end

    always_comb begin
        rr0_tag_low = head_q[0];
        rr1_tag_low = head_q[1];
        rr2_tag_low = head_q[2];
        rr3_tag_low = head_q[3];
        for (int i = 0; i < NumCh; i++) begin
            busy[i] = (cnt_q[i] != 4'd0);
        end
        ret_valid   = ret_q;
        outstanding = out_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_fpc_tag_pool.sv
// Bench for fpc_tag_pool: queue-based issue-order model checked every cycle, plus literal pins.
module tb_fpc_tag_pool;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [3:0] enable   = 4'hF;
    logic [3:0] rr_ready = 4'h0;
    logic [3:0] rdy5     = 4'h0;
    logic       c_valid  = 1'b0;
    logic [7:0] c_tag    = 8'h00;

    logic [3:0] rr_valid, ret_valid, busy;
    logic [2:0] t0, t1, t2, t3;
    logic [5:0] outstanding;
    logic       err;

    logic [3:0] rv5, ret5, busy5;
    logic [2:0] u0, u1, u2, u3;
    logic [5:0] out5;
    logic       err5;

    always #5 clock = ~clock;

    fpc_tag_pool dut (
        .clock(clock), .reset(reset), .enable(enable), .rr_valid(rr_valid), .rr_ready(rr_ready),
        .rr0_tag_low(t0), .rr1_tag_low(t1), .rr2_tag_low(t2), .rr3_tag_low(t3),
        .c_valid(c_valid), .c_tag(c_tag), .ret_valid(ret_valid), .busy(busy),
        .outstanding(outstanding), .err(err)
    );

    fpc_tag_pool #(.TAGS(8), .MAX_OUTSTANDING(5)) dut5 (
        .clock(clock), .reset(reset), .enable(enable), .rr_valid(rv5), .rr_ready(rdy5),
        .rr0_tag_low(u0), .rr1_tag_low(u1), .rr2_tag_low(u2), .rr3_tag_low(u3),
        .c_valid(c_valid), .c_tag(c_tag), .ret_valid(ret5), .busy(busy5),
        .outstanding(out5), .err(err5)
    );

    // ---------------- behavioural model of dut (MAX_OUTSTANDING = 32) ----------------
    localparam int MaxOut = 32;
    int       mq [4][$];   // issued tags per channel, oldest first
    bit [7:0] mdone [4];
    int       mnext [4];
    bit       merr    = 1'b0;
    bit [3:0] mret    = 4'h0;
    bit       mactive = 1'b0;

    function automatic int mtotal();
        int s = 0;
        for (int i = 0; i < 4; i++) s += mq[i].size();
        return s;
    endfunction

    function automatic bit [3:0] mvalid();
        bit [3:0] v = 4'h0;
        for (int i = 0; i < 4; i++)
            v[i] = mactive && enable[i] && (mq[i].size() < 8) && (mtotal() < MaxOut);
        return v;
    endfunction

    function automatic bit in_queue(int ch, int t);
        foreach (mq[ch][k]) if (mq[ch][k] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit [3:0] mbusy();
        bit [3:0] b = 4'h0;
        for (int i = 0; i < 4; i++) b[i] = (mq[i].size() > 0);
        return b;
    endfunction

    initial begin
        forever begin
            bit [3:0] v, rnow;
            int       room, ch, t;
            bit       cok;
            @(posedge clock or negedge reset);
            if (!reset) begin
                for (int i = 0; i < 4; i++) begin
                    mq[i].delete();
                    mdone[i] = 8'h00;
                    mnext[i] = 0;
                end
                merr = 1'b0;
                mret = 4'h0;
                mactive = 1'b0;
            end else begin
                v    = mvalid();
                room = mtotal();
                rnow = 4'h0;
                for (int i = 0; i < 4; i++)
                    if (mq[i].size() > 0 && mdone[i][mq[i][0]]) rnow[i] = 1'b1;
                ch  = int'(c_tag[5:4]);
                t   = int'(c_tag[2:0]);
                cok = (c_tag[7:6] == 2'b00) && !c_tag[3] && in_queue(ch, t) && !mdone[ch][t];
                for (int i = 0; i < 4; i++) begin
                    if (rnow[i]) begin
                        mdone[i][mq[i][0]] = 1'b0;
                        void'(mq[i].pop_front());
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (rr_ready[i]) begin
                        if (v[i] && room < MaxOut) begin
                            mq[i].push_back(mnext[i]);
                            mnext[i] = (mnext[i] + 1) % 8;
                            room++;
                        end else begin
                            merr = 1'b1;
                        end
                    end
                end
                if (c_valid) begin
                    if (cok) mdone[ch][t] = 1'b1;
                    else merr = 1'b1;
                end
                mret    = rnow;
                mactive = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    int n_err = 0;
    int n_chk = 0;

    localparam int SelRv = 0, SelT0 = 1, SelRet = 5, SelBusy = 6, SelOut = 7, SelErr = 8;
    localparam int SelRv5 = 9, SelOut5 = 10, SelRet5 = 11;

    string pin_name = "";
    int    pin_sel  = 0;
    int    pin_exp  = 0;
    int    pin_seq  = 0;
    int    pin_seen = 0;

    function automatic int sel_value(int sel);
        case (sel)
            SelRv:   return int'(rr_valid);
            1:       return int'(t0);
            2:       return int'(t1);
            3:       return int'(t2);
            4:       return int'(t3);
            SelRet:  return int'(ret_valid);
            SelBusy: return int'(busy);
            SelOut:  return int'(outstanding);
            SelErr:  return int'(err);
            SelRv5:  return int'(rv5);
            SelOut5: return int'(out5);
            SelRet5: return int'(ret5);
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            chk("rr_valid", int'(rr_valid), int'(mvalid()));
            chk("rr0_tag_low", int'(t0), mnext[0]);
            chk("rr1_tag_low", int'(t1), mnext[1]);
            chk("rr2_tag_low", int'(t2), mnext[2]);
            chk("rr3_tag_low", int'(t3), mnext[3]);
            chk("ret_valid", int'(ret_valid), int'(mret));
            chk("busy", int'(busy), int'(mbusy()));
            chk("outstanding", int'(outstanding), mtotal());
            chk("err", int'(err), int'(merr));
            if (pin_seq != pin_seen) begin
                pin_seen = pin_seq;
                chk(pin_name, sel_value(pin_sel), pin_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pin(input string name, input int sel, input int exp);
        pin_name = name;
        pin_sel  = sel;
        pin_exp  = exp;
        pin_seq++;
    endtask

    task automatic pin_tick(input string name, input int sel, input int exp);
        pin(name, sel, exp);
        tick();
    endtask

    task automatic alloc(input int ch);
        rr_ready = 4'(1 << ch);
        tick();
        rr_ready = 4'h0;
    endtask

    task automatic alloc5(input int ch);
        rdy5 = 4'(1 << ch);
        tick();
        rdy5 = 4'h0;
    endtask

    task automatic complete(input logic [7:0] tag);
        c_valid = 1'b1;
        c_tag   = tag;
        tick();
        c_valid = 1'b0;
        c_tag   = 8'h00;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        rr_ready = 4'h0;
        rdy5     = 4'h0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #1 reset = 1'b0;
        tick();
        pin_tick("reset_rr_valid", SelRv, 0);
        reset = 1'b1;
        pin("rr_valid_before_first_edge", SelRv, 0);
        tick();
        pin("rr_valid_after_release", SelRv, 15);

        // Fill channel 0: tags 0..7 in order.
        for (int k = 0; k < 8; k++) begin
            pin("issue_tag", SelT0, k);
            alloc(0);
        end
        pin_tick("full_rr_valid", SelRv, 4'hE);
        pin_tick("full_outstanding", SelOut, 8);
        pin_tick("full_busy", SelBusy, 1);
        pin_tick("full_head_wrapped", SelT0, 0);

        // Out-of-order completions 3,1,0,2 retire in order 0..3.
        pin("ooo_no_ret0", SelRet, 0);  complete(8'h03);
        pin("ooo_no_ret1", SelRet, 0);  complete(8'h01);
        pin("ooo_no_ret2", SelRet, 0);  complete(8'h00);
        pin("ooo_no_ret3", SelRet, 0);  complete(8'h02);
        pin_tick("ooo_ret_tag0", SelRet, 1);
        pin_tick("ooo_ret_tag1", SelRet, 1);
        pin_tick("ooo_ret_tag2", SelRet, 1);
        pin_tick("ooo_ret_tag3", SelRet, 1);
        pin_tick("ooo_ret_end", SelRet, 0);
        pin_tick("ooo_outstanding", SelOut, 4);

        // Drain tags 4..7, then wrap and reissue 0,1,2.
        complete(8'h04); complete(8'h05); complete(8'h06); complete(8'h07);
        pin_tick("drain_ret", SelRet, 1);
        pin_tick("drain_outstanding", SelOut, 0);
        pin_tick("drain_busy", SelBusy, 0);
        pin("wrap_head", SelT0, 0);
        alloc(0); alloc(0); alloc(0);
        pin_tick("wrap_head_after3", SelT0, 3);
        complete(8'h00); complete(8'h01); complete(8'h02);
        pin_tick("wrap_ret1", SelRet, 1);
        pin_tick("wrap_ret2", SelRet, 1);
        pin_tick("wrap_outstanding", SelOut, 0);

        // Reserved format bit set on an otherwise live tag.
        do_reset();
        alloc(0); alloc(0); alloc(0); alloc(0);
        complete(8'h0B);
        pin_tick("err_reserved_bit", SelErr, 1);
        pin_tick("err_reserved_out", SelOut, 4);
        tick(); tick();

        // Completion of a free tag.
        do_reset();
        alloc(1);
        complete(8'h11);
        pin_tick("err_free_tag", SelErr, 1);
        pin_tick("err_free_out", SelOut, 1);

        // Double completion.
        do_reset();
        alloc(1); alloc(1);
        complete(8'h11);
        pin_tick("first_completion_ok", SelErr, 0);
        complete(8'h11);
        pin_tick("err_double", SelErr, 1);
        pin_tick("err_double_out", SelOut, 2);
        complete(8'h10);
        tick();
        pin_tick("double_ret_a", SelRet, 2);
        pin_tick("double_ret_b", SelRet, 2);
        pin_tick("double_out_end", SelOut, 0);

        // rr_ready without rr_valid, then a disabled channel still drains.
        do_reset();
        enable = 4'hE;
        pin_tick("disabled_rr_valid", SelRv, 4'hE);
        rr_ready = 4'h1;
        tick();
        rr_ready = 4'h0;
        pin_tick("err_ready_no_valid", SelErr, 1);
        pin_tick("ready_no_valid_head", SelT0, 0);
        pin_tick("ready_no_valid_out", SelOut, 0);
        enable = 4'hF;
        alloc(3); alloc(3);
        enable = 4'h0;
        pin_tick("all_disabled_rr_valid", SelRv, 0);
        complete(8'h30); complete(8'h31);
        pin_tick("disabled_busy_one_left", SelBusy, 8);
        pin_tick("disabled_ret", SelRet, 8);
        pin_tick("disabled_busy_clear", SelBusy, 0);
        enable = 4'hF;

        // Outstanding cap of 5 on the second instance.
        do_reset();
        alloc5(0); alloc5(1); alloc5(2); alloc5(3);
        pin_tick("cap_below", SelRv5, 15);
        alloc5(0);
        pin_tick("cap_reached_rr_valid", SelRv5, 0);
        pin_tick("cap_reached_out", SelOut5, 5);
        complete(8'h00);
        pin_tick("cap_still_full", SelRv5, 0);
        pin_tick("cap_ret", SelRet5, 1);
        pin_tick("cap_reopened", SelRv5, 15);
        pin_tick("cap_out_after_ret", SelOut5, 4);

        // Channel 2: allocation and retirement in the same cycle.
        do_reset();
        for (int k = 0; k < 8; k++) alloc(2);
        pin_tick("ch2_full", SelRv, 4'hB);
        complete(8'h20);
        pin("ch2_still_full", SelRv, 4'hB);
        complete(8'h21);
        pin("ch2_slot_free", SelRv, 15);
        rr_ready = 4'h4;
        tick();
        rr_ready = 4'h0;
        pin_tick("ch2_alloc_retire_out", SelOut, 7);
        pin("ch2_refill_valid", SelRv, 15);
        alloc(2);
        pin_tick("ch2_refull_out", SelOut, 8);
        pin_tick("ch2_refull_rv", SelRv, 4'hB);

        // Reset mid-burst clears everything without a clock edge.
        rr_ready = 4'h2;
        tick();
        tick();
        #1;
        reset    = 1'b0;
        rr_ready = 4'h0;
        pin("async_reset_out", SelOut, 0);
        @(posedge clock);
        #1;
        pin_tick("async_reset_rv", SelRv, 0);
        reset = 1'b1;
        tick();
        complete(8'h10);
        pin_tick("late_completion_err", SelErr, 1);
        pin_tick("late_completion_out", SelOut, 0);
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
